// File: rtl/mux_tree_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined mux tree.
// Level k of the tree reads N>>k words from a flat bus that chains all levels.
package mux_tree_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_N     = 8;
    localparam int DEF_CNT_W = 16;

    // Number of words entering tree level k.
    function automatic int level_words(input int n, input int k);
        return n >> k;
    endfunction

    // Word offset of level k's input in the flat data bus.
    // Levels 0..k-1 together hold N + N/2 + ... words, which is 2*(N - (N>>k)).
    function automatic int word_offset(input int n, input int k);
        return 2 * (n - (n >> k));
    endfunction

    // Bit offset of level k's input select in the flat select bus.
    // Level i consumes a select of width sel_w-i.
    function automatic int sel_offset(input int sel_w, input int k);
        return k * sel_w - (k * (k - 1)) / 2;
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One registered level of the mux tree: IN_WORDS/2 2:1 muxes steered by select
// bit 0, plus the word/select/valid registers and this level's stage enable.
module mux_tree_stage
    import mux_tree_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int IN_WORDS  = DEF_N,
    parameter int REM_SEL_W = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    up_valid,
    input  logic [IN_WORDS*WIDTH-1:0]               up_data,
    input  logic [REM_SEL_W:0]                      up_sel,
    input  logic                                    dn_en,
    output logic                                    en,
    output logic                                    valid,
    output logic [(IN_WORDS/2)*WIDTH-1:0]           data,
    output logic [((REM_SEL_W > 0) ? REM_SEL_W : 1)-1:0] sel
);

    localparam int OUT_WORDS = IN_WORDS / 2;
    localparam int SEL_Q_W   = (REM_SEL_W > 0) ? REM_SEL_W : 1;

    logic [OUT_WORDS*WIDTH-1:0] mux_out;
    logic [SEL_Q_W-1:0]         sel_next;
    logic                       load;

    for (genvar j = 0; j < OUT_WORDS; j++) begin : g_mux
        assign mux_out[j*WIDTH +: WIDTH] = up_sel[0] ? up_data[(2*j+1)*WIDTH +: WIDTH]
                                                     : up_data[(2*j)*WIDTH +: WIDTH];
    end

    // The last level has no select bits left to carry; its select register is a constant.
    if (REM_SEL_W > 0) begin : g_sel_carry
        assign sel_next = up_sel[REM_SEL_W:1];
    end else begin : g_sel_none
        assign sel_next = '0;
    end

    // A slot may advance when it is empty or when the slot after it is advancing too.
    assign en   = !valid || dn_en;
    assign load = en && up_valid;

    // NOTE: the word and select registers are reset as well as valid, so that
    // out_data reads zero after reset rather than whatever was in flight; all
    // state updates use non-blocking assignments so the levels shift as one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            sel   <= '0;
        end else begin
            if (en) begin
                valid <= up_valid;
            end
            if (load) begin
                data <= mux_out;
                sel  <= sel_next;
            end
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer: SEL_W registered 2:1 levels behind a valid/ready
// handshake with bubble collapse. Define MUX_TREE_PIPE_XFER_CNT_EN to add xfer_cnt.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int SEL_W = $clog2(N),
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]     in_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data
`ifdef MUX_TREE_PIPE_XFER_CNT_EN
    ,
    output logic [CNT_W-1:0]     xfer_cnt
`endif
);

    localparam int L      = SEL_W;
    localparam int DBUS_W = (2 * N - 1) * WIDTH;
    localparam int SBUS_W = sel_offset(SEL_W, L);

    // Flat buses chain the levels: level k reads slice k and writes slice k+1.
    logic [DBUS_W-1:0] data_bus;
    logic [SBUS_W-1:0] sel_bus;
    logic [L:0]        valid_bus;
    logic [L:0]        en_bus;

    assign data_bus[N*WIDTH-1:0] = in_data;
    assign sel_bus[SEL_W-1:0]    = in_sel;
    assign valid_bus[0]          = in_valid;
    assign en_bus[L]             = out_ready;

    assign in_ready  = en_bus[0];
    assign out_valid = valid_bus[L];
    assign out_data  = data_bus[DBUS_W-1 -: WIDTH];

    for (genvar k = 0; k < L; k++) begin : g_level
        localparam int IN_WORDS = level_words(N, k);
        localparam int REM      = SEL_W - k - 1;
        localparam int SQ_W     = (REM > 0) ? REM : 1;
        localparam int IN_OFF   = word_offset(N, k) * WIDTH;
        localparam int OUT_OFF  = word_offset(N, k + 1) * WIDTH;
        localparam int SIN_OFF  = sel_offset(SEL_W, k);
        localparam int SOUT_OFF = sel_offset(SEL_W, k + 1);

        logic [SQ_W-1:0] sel_q;

        mux_tree_stage #(
            .WIDTH     (WIDTH),
            .IN_WORDS  (IN_WORDS),
            .REM_SEL_W (REM)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (valid_bus[k]),
            .up_data  (data_bus[IN_OFF +: IN_WORDS*WIDTH]),
            .up_sel   (sel_bus[SIN_OFF +: REM+1]),
            .dn_en    (en_bus[k+1]),
            .en       (en_bus[k]),
            .valid    (valid_bus[k+1]),
            .data     (data_bus[OUT_OFF +: (IN_WORDS/2)*WIDTH]),
            .sel      (sel_q)
        );

        if (REM > 0) begin : g_sel_fwd
            assign sel_bus[SOUT_OFF +: REM] = sel_q;
        end else begin : g_sel_end
            logic sel_unused;
            assign sel_unused = sel_q[0];
        end
    end

`ifdef MUX_TREE_PIPE_XFER_CNT_EN
    // Counts completed output handshakes and wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end
`else
    // Datapath only: no transfer counter in this build.
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: an N=8/WIDTH=4 instance and an N=2/WIDTH=8 instance.
// The transfer-counter checks run when MUX_TREE_PIPE_XFER_CNT_EN is defined.
module tb_mux_tree_pipe;

    logic clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data;
    logic [2:0]  a_in_sel;
    logic [3:0]  a_out_data;
`ifdef MUX_TREE_PIPE_XFER_CNT_EN
    logic [3:0]  a_xfer_cnt;
    logic [7:0]  b_xfer_cnt;
`endif

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0] b_in_data;
    logic [0:0]  b_in_sel;
    logic [7:0]  b_out_data;

    int checks   = 0;
    int failures = 0;

    mux_tree_pipe #(.WIDTH(4), .N(8), .CNT_W(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_sel    (a_in_sel),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data)
`ifdef MUX_TREE_PIPE_XFER_CNT_EN
        ,
        .xfer_cnt  (a_xfer_cnt)
`endif
    );

    mux_tree_pipe #(.WIDTH(8), .N(2), .CNT_W(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data)
`ifdef MUX_TREE_PIPE_XFER_CNT_EN
        ,
        .xfer_cnt  (b_xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    typedef struct {
        logic        in_valid;
        logic [31:0] data;
        logic [2:0]  sel;
        logic        exp_valid;
        logic [3:0]  exp_data;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [0:NV-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] d, input logic [2:0] s);
        a_in_valid = v;
        a_in_data  = d;
        a_in_sel   = s;
    endtask

    initial begin
        // word i of 0x87654321 is i+1; of 0x89ABCDEF is 15-i
        vecs[0] = '{1'b1, 32'h8765_4321, 3'd5, 1'b1, 4'h6};
        for (int i = 0; i < 8; i++) begin
            vecs[1+i] = '{1'b1, 32'h8765_4321, 3'(i), 1'b1, 4'(i + 1)};
        end
        vecs[9]  = '{1'b1, 32'h89AB_CDEF, 3'd3, 1'b1, 4'hC};
        vecs[10] = '{1'b0, 32'hFFFF_FFFF, 3'd7, 1'b0, 4'h0};
        vecs[11] = '{1'b1, 32'h89AB_CDEF, 3'd6, 1'b1, 4'h9};
        vecs[12] = '{1'b1, 32'h0000_F000, 3'd3, 1'b1, 4'hF};
        vecs[13] = '{1'b1, 32'h0000_F000, 3'd2, 1'b1, 4'h0};

        rst_n = 1'b0;
        drive_a(1'b0, 32'h0, 3'd0);
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = 16'h55AA;
        b_in_sel    = 1'b0;
        b_out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_data",  32'(a_out_data),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", 32'(a_out_valid), 32'd0);
        check("post_rst_in_ready",  32'(a_in_ready),  32'd1);
`ifdef MUX_TREE_PIPE_XFER_CNT_EN
        check("rst_xfer_cnt", 32'(a_xfer_cnt), 32'd0);
`endif
        tick();

        // Single word, latency 3
        drive_a(1'b1, 32'h8765_4321, 3'd5);
        tick();
        drive_a(1'b0, 32'h0, 3'd0);
        check("lat_c1_valid", 32'(a_out_valid), 32'd0);
        tick();
        check("lat_c2_valid", 32'(a_out_valid), 32'd0);
        tick();
        check("lat_c3_valid", 32'(a_out_valid), 32'd1);
        check("lat_c3_data",  32'(a_out_data),  32'd6);
        tick();
        check("lat_c4_valid", 32'(a_out_valid), 32'd0);

        // Table-driven back-to-back stream with out_ready high
        for (int c = 0; c < NV + 3; c++) begin
            if (c < NV) drive_a(vecs[c].in_valid, vecs[c].data, vecs[c].sel);
            else        drive_a(1'b0, 32'hDEAD_BEEF, 3'd7);
            @(negedge clk);
            check($sformatf("stream_in_ready[%0d]", c), 32'(a_in_ready), 32'd1);
            tick();
            if (c >= 2 && c - 2 < NV) begin
                check($sformatf("stream_valid[%0d]", c - 2), 32'(a_out_valid), 32'(vecs[c-2].exp_valid));
                if (vecs[c-2].exp_valid)
                    check($sformatf("stream_data[%0d]", c - 2), 32'(a_out_data), 32'(vecs[c-2].exp_data));
            end else begin
                check($sformatf("stream_idle_valid[%0d]", c), 32'(a_out_valid), 32'd0);
            end
        end

        // Stalled output: three words fill the pipe, then in_ready drops
        a_out_ready = 1'b0;
        for (int w = 0; w < 5; w++) begin
            drive_a(1'b1, 32'h8765_4321, 3'(w));
            @(negedge clk);
            check($sformatf("stall_in_ready[%0d]", w), 32'(a_in_ready), (w < 3) ? 32'd1 : 32'd0);
            if (w >= 3) begin
                check($sformatf("stall_out_valid[%0d]", w), 32'(a_out_valid), 32'd1);
                check($sformatf("stall_out_data[%0d]", w),  32'(a_out_data),  32'd1);
            end
            tick();
        end
        drive_a(1'b0, 32'h0, 3'd0);
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("drain_valid[%0d]", i), 32'(a_out_valid), 32'd1);
            check($sformatf("drain_data[%0d]", i),  32'(a_out_data),  32'(i + 1));
            tick();
        end
        @(negedge clk);
        check("drain_empty_valid", 32'(a_out_valid), 32'd0);
        check("drain_in_ready",    32'(a_in_ready),  32'd1);
        tick();

        // Asynchronous reset with two words in flight
        a_out_ready = 1'b0;
        drive_a(1'b1, 32'h8765_4321, 3'd7);
        tick();
        drive_a(1'b1, 32'h8765_4321, 3'd6);
        tick();
        drive_a(1'b0, 32'h0, 3'd0);
        tick();
        check("pre_rst_valid", 32'(a_out_valid), 32'd1);
        check("pre_rst_data",  32'(a_out_data),  32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",    32'(a_out_valid), 32'd0);
        check("async_rst_data",     32'(a_out_data),  32'd0);
        check("async_rst_in_ready", 32'(a_in_ready),  32'd1);
        tick();
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("no_stale_valid[%0d]", i), 32'(a_out_valid), 32'd0);
            check($sformatf("no_stale_ready[%0d]", i), 32'(a_in_ready),  32'd1);
            tick();
        end

        // N=2 instance: latency 1, alternating select
        for (int c = 0; c < 5; c++) begin
            b_in_valid = (c < 4);
            b_in_sel   = (c % 2 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            check($sformatf("n2_in_ready[%0d]", c), 32'(b_in_ready), 32'd1);
            tick();
            if (c < 4) begin
                check($sformatf("n2_valid[%0d]", c), 32'(b_out_valid), 32'd1);
                check($sformatf("n2_data[%0d]", c),  32'(b_out_data), (c % 2 == 0) ? 32'h55 : 32'hAA);
            end else begin
                check("n2_idle_valid", 32'(b_out_valid), 32'd0);
            end
        end
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_sel    = 1'b1;
        tick();
        b_in_valid = 1'b0;
        @(negedge clk);
        check("n2_stall_valid", 32'(b_out_valid), 32'd1);
        check("n2_stall_ready", 32'(b_in_ready),  32'd0);
        check("n2_stall_data",  32'(b_out_data),  32'h55);
        b_out_ready = 1'b1;
        tick();
        check("n2_drained_valid", 32'(b_out_valid), 32'd0);

`ifdef MUX_TREE_PIPE_XFER_CNT_EN
        // 17 transfers on a 4-bit counter wrap to 1
        check("cnt_before", 32'(a_xfer_cnt), 32'd0);
        for (int i = 0; i < 17; i++) begin
            drive_a(1'b1, 32'h8765_4321, 3'd0);
            tick();
        end
        drive_a(1'b0, 32'h0, 3'd0);
        tick();
        tick();
        tick();
        check("cnt_wrap", 32'(a_xfer_cnt), 32'd1);
        a_out_ready = 1'b0;
        drive_a(1'b1, 32'h8765_4321, 3'd1);
        tick();
        drive_a(1'b0, 32'h0, 3'd0);
        for (int i = 0; i < 4; i++) tick();
        check("cnt_stall_valid", 32'(a_out_valid), 32'd1);
        check("cnt_stall_hold",  32'(a_xfer_cnt),  32'd1);
        a_out_ready = 1'b1;
        tick();
        check("cnt_after_stall", 32'(a_xfer_cnt), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
